// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB pipeline register: runs loads/stores over a
// req/ack SRAM port and stalls upstream while busy. Optional SRAM_TIMEOUT_EN adds an access watchdog.
module mem_wb_stage #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic [31:0]       alu_result_in,
  input  logic [31:0]       st_val_in,
  input  logic [3:0]        dest_in,
  output logic              freeze,
  output logic              sram_req,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  input  logic              sram_ack,
  output logic [3:0]        Dest_wb,
  output logic [31:0]       Result_WB,
  output logic              writeBackEn,
  output logic              mem_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic              load_q, load_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       addr_off;
  logic              mem_op;
  logic              to_hit;

  assign mem_op   = mem_r_en_in | mem_w_en_in;
  // Data memory starts at byte 1024; SRAM is word addressed.
  assign addr_off = alu_result_in - 32'd1024;

  assign sram_req   = (state_q == ACCESS);
  assign sram_we    = we_q;
  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;

`ifdef SRAM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  assign to_hit  = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign mem_err = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= (state_q == ACCESS) ? cnt_q + 1'b1 : '0;
      // An ack on the last allowed cycle is a normal completion.
      if (state_q == ACCESS && !sram_ack && to_hit) err_q <= 1'b1;
    end
  end
`else
  assign to_hit  = 1'b0;
  assign mem_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    load_d  = load_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    freeze  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          freeze  = 1'b1;
          we_d    = mem_w_en_in;
          load_d  = mem_r_en_in & ~mem_w_en_in;  // store wins when both set
          addr_d  = addr_off[ADDR_W+1:2];
          wdata_d = st_val_in;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        freeze = 1'b1;
        if (sram_ack) begin
          rdata_d = sram_rdata;
          state_d = DONE;
        end else if (to_hit) begin
          rdata_d = 32'hDEADBEEF;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      load_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      load_q  <= load_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // MEM/WB register: a frozen cycle inserts a bubble and keeps the old value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      Dest_wb     <= '0;
      Result_WB   <= '0;
      writeBackEn <= 1'b0;
    end else if (freeze) begin
      writeBackEn <= 1'b0;
    end else begin
      Dest_wb     <= dest_in;
      writeBackEn <= wb_en_in;
      Result_WB   <= (state_q == DONE && load_q) ? rdata_q : alu_result_in;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: table-driven ALU vectors plus hand-built
// load/store/reset/timeout sequences against a req/ack SRAM driven by the bench.
module tb_mem_wb_stage;

`ifdef SRAM_TIMEOUT_EN
  localparam int TB_TO = 4;
`else
  localparam int TB_TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_en_in = 1'b0, mem_r_en_in = 1'b0, mem_w_en_in = 1'b0;
  logic [31:0] alu_result_in = '0, st_val_in = '0;
  logic [3:0]  dest_in = '0;
  logic        freeze, sram_req, sram_we;
  logic [15:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata = '0;
  logic        sram_ack = 1'b0;
  logic [3:0]  Dest_wb;
  logic [31:0] Result_WB;
  logic        writeBackEn, mem_err;

  int checks = 0;
  int errors = 0;

  mem_wb_stage #(.ADDR_W(16), .TIMEOUT(TB_TO)) dut (
    .clk(clk), .rst(rst), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
    .mem_w_en_in(mem_w_en_in), .alu_result_in(alu_result_in), .st_val_in(st_val_in),
    .dest_in(dest_in), .freeze(freeze), .sram_req(sram_req), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_ack(sram_ack), .Dest_wb(Dest_wb), .Result_WB(Result_WB),
    .writeBackEn(writeBackEn), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic nop();
    wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0;
    alu_result_in = '0; st_val_in = '0; dest_in = '0;
  endtask

  typedef struct {
    logic        wb;
    logic [31:0] alu;
    logic [3:0]  dest;
  } alu_vec_t;

  // Non-memory op: present at negedge, expect it in the MEM/WB register one cycle later.
  task automatic apply_alu(input alu_vec_t v, input string tag);
    wb_en_in = v.wb; alu_result_in = v.alu; dest_in = v.dest;
    mem_r_en_in = 0; mem_w_en_in = 0;
    #1 chk({tag, " freeze"}, {31'd0, freeze}, 32'd0);
    @(negedge clk);
    chk({tag, " Dest_wb"}, {28'd0, Dest_wb}, {28'd0, v.dest});
    chk({tag, " Result_WB"}, Result_WB, v.alu);
    chk({tag, " writeBackEn"}, {31'd0, writeBackEn}, {31'd0, v.wb});
  endtask

  // Memory op with ack on the k-th request cycle (k=0: never ack).
  task automatic mem_op(input logic r, input logic w, input logic [31:0] alu,
                        input logic [31:0] st, input logic [3:0] d, input logic wb,
                        input int k, input logic [31:0] rd, input logic [15:0] exp_addr,
                        input int exp_freeze, input logic [31:0] exp_res, input string tag);
    int  fcnt = 0, rcnt = 0;
    bit  done = 0;
    wb_en_in = wb; mem_r_en_in = r; mem_w_en_in = w;
    alu_result_in = alu; st_val_in = st; dest_in = d;
    for (int c = 0; c < 400 && !done; c++) begin
      #1;
      if (freeze) fcnt++;
      if (c > 0 && freeze) chk({tag, " bubble"}, {31'd0, writeBackEn}, 32'd0);
      if (sram_req) begin
        rcnt++;
        if (rcnt == 1) begin
          chk({tag, " sram_addr"}, {16'd0, sram_addr}, {16'd0, exp_addr});
          chk({tag, " sram_we"}, {31'd0, sram_we}, {31'd0, w});
          if (w) chk({tag, " sram_wdata"}, sram_wdata, st);
        end
        sram_ack = (rcnt == k);
        sram_rdata = rd;
      end else begin
        sram_ack = 0;
      end
      if (!freeze && c > 0) done = 1;
      @(negedge clk);
    end
    sram_ack = 0;
    if (!done) chk({tag, " completion"}, 32'd0, 32'd1);
    chk({tag, " freeze cycles"}, fcnt, exp_freeze);
    chk({tag, " req dropped"}, {31'd0, sram_req}, 32'd0);
    chk({tag, " Dest_wb"}, {28'd0, Dest_wb}, {28'd0, d});
    chk({tag, " Result_WB"}, Result_WB, exp_res);
    chk({tag, " writeBackEn"}, {31'd0, writeBackEn}, {31'd0, wb});
    nop();
  endtask

  alu_vec_t vecs[5];

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0055, 4'd3};
    vecs[1] = '{1'b0, 32'hFFFF_FFFF, 4'd15};
    vecs[2] = '{1'b1, 32'h8000_0001, 4'd0};
    vecs[3] = '{1'b1, 32'h0000_0400, 4'd9};
    vecs[4] = '{1'b1, 32'h1234_ABCD, 4'd7};

    #12;
    chk("reset sram_req", {31'd0, sram_req}, 32'd0);
    chk("reset sram_addr", {16'd0, sram_addr}, 32'd0);
    chk("reset Result_WB", Result_WB, 32'd0);
    chk("reset writeBackEn", {31'd0, writeBackEn}, 32'd0);
    chk("reset mem_err", {31'd0, mem_err}, 32'd0);
    @(negedge clk); rst = 1;
    @(negedge clk);

    foreach (vecs[i]) apply_alu(vecs[i], $sformatf("alu%0d", i));

    // Load at 1028, ack on second request cycle.
    mem_op(1, 0, 32'd1028, 32'h0, 4'd5, 1, 2, 32'hCAFEF00D, 16'd1, 3, 32'hCAFEF00D, "load");
    apply_alu('{1'b1, 32'h0000_0077, 4'd2}, "alu after load");
    // Store at 1032, ack in first request cycle, no write-back.
    mem_op(0, 1, 32'd1032, 32'h12345678, 4'd4, 0, 1, 32'h0, 16'd2, 2, 32'd1032, "store");
    // Both enables: store wins, write-back value is the address.
    mem_op(1, 1, 32'h400, 32'hA5A5A5A5, 4'd6, 1, 3, 32'h0BAD0BAD, 16'd0, 4, 32'h400, "both");
    // Back-to-back loads.
    mem_op(1, 0, 32'd2048, 32'h0, 4'd8, 1, 1, 32'h11112222, 16'd256, 2, 32'h11112222, "b2b load1");
    mem_op(1, 0, 32'd2052, 32'h0, 4'd9, 1, 1, 32'h33334444, 16'd257, 2, 32'h33334444, "b2b load2");

    // Reset asserted mid-access, late ack ignored.
    wb_en_in = 1; mem_r_en_in = 1; alu_result_in = 32'd1036; dest_in = 4'd11;
    @(negedge clk);
    #1 chk("rst-mid req before", {31'd0, sram_req}, 32'd1);
    #1 rst = 0;
    #1 chk("rst-mid req async drop", {31'd0, sram_req}, 32'd0);
    chk("rst-mid Result_WB", Result_WB, 32'd0);
    chk("rst-mid Dest_wb", {28'd0, Dest_wb}, 32'd0);
    nop();
    sram_ack = 1; sram_rdata = 32'hBAADF00D;
    @(negedge clk); rst = 1;
    @(negedge clk); sram_ack = 0;
    #1 chk("rst-mid late ack req", {31'd0, sram_req}, 32'd0);
    chk("rst-mid late ack wbe", {31'd0, writeBackEn}, 32'd0);
    chk("rst-mid late ack result", Result_WB, 32'd0);
    @(negedge clk);
    apply_alu('{1'b1, 32'h0000_0099, 4'd1}, "alu after reset");

`ifdef SRAM_TIMEOUT_EN
    mem_op(1, 0, 32'd1040, 32'h0, 4'd12, 1, 0, 32'h0, 16'd4, TB_TO + 1, 32'hDEADBEEF, "timeout");
    chk("timeout mem_err", {31'd0, mem_err}, 32'd1);
    mem_op(1, 0, 32'd1044, 32'h0, 4'd13, 1, TB_TO, 32'h5A5A5A5A, 16'd5, TB_TO + 1, 32'h5A5A5A5A, "ack on limit");
    chk("mem_err sticky", {31'd0, mem_err}, 32'd1);
    @(negedge clk); rst = 0;
    #1 chk("mem_err cleared", {31'd0, mem_err}, 32'd0);
    @(negedge clk); rst = 1;
`else
    chk("mem_err tied", {31'd0, mem_err}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access stage plus MEM/WB pipeline register of the ARM pipeline, sitting directly upstream of the register file. Takes the EX/MEM-stage control and data, performs loads and stores against an external word-wide SRAM through a req/ack handshake, and freezes the rest of the pipeline while an access is outstanding. Its registered outputs are the register file's write-back inputs: destination, value and write enable.

## Interface
- `ADDR_W`, 16: SRAM word-address width.
- `TIMEOUT`, 255: max ACCESS cycles before abort; used only with `SRAM_TIMEOUT_EN`.
- `clk`  in  1  pipeline clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low (asserted at 0).
- `wb_en_in`  in  1  instruction writes a register.
- `mem_r_en_in`  in  1  load.
- `mem_w_en_in`  in  1  store.
- `alu_result_in`  in  32  effective address, or result for non-loads.
- `st_val_in`  in  32  store data.
- `dest_in`  in  4  destination register.
- `freeze`  out  1  combinational stall to IF/ID/EX stages and their pipeline registers.
- `sram_req`  out  1  access request, held until ack.
- `sram_we`  out  1  1 = write, 0 = read; valid with `sram_req`.
- `sram_addr`  out  ADDR_W  word address.
- `sram_wdata`  out  32  write data.
- `sram_rdata`  in  32  read data, valid with `sram_ack`.
- `sram_ack`  in  1  access complete.
- `Dest_wb`  out  4  registered destination to register file.
- `Result_WB`  out  32  registered write-back value.
- `writeBackEn`  out  1  registered write enable.
- `mem_err`  out  1  sticky timeout flag; constant 0 without `SRAM_TIMEOUT_EN`.

## Operation
- FSM states IDLE, ACCESS, DONE. Reset: IDLE; `sram_req`, `sram_we`, `sram_addr`, `sram_wdata`, `Dest_wb`, `Result_WB`, `writeBackEn`, `mem_err` all 0.
- IDLE: if `mem_r_en_in | mem_w_en_in` → latch address, store data and type, go ACCESS; `freeze`=1 this cycle. Otherwise `freeze`=0 and instruction passes to MEM/WB register.
- Address: `sram_addr = ((alu_result_in - 32'd1024) >> 2)[ADDR_W-1:0]`; low two address bits ignored.
- Both enables set: store wins, no load; write-back value is `alu_result_in`.
- ACCESS: `sram_req`=1, `sram_we`/`sram_addr`/`sram_wdata` from latched values, stable until ack. `freeze`=1. On `sram_ack` sampled high: capture `sram_rdata` (reads), go DONE.
- DONE: `sram_req`=0, `freeze`=0; MEM/WB register loads this instruction at cycle end; go IDLE. Upstream still holds the same instruction during DONE, so it is not re-issued.
- MEM/WB register, loaded every edge: `freeze`=1 → `writeBackEn`<=0 (bubble), `Dest_wb`/`Result_WB` hold; else `Dest_wb`<=`dest_in`, `writeBackEn`<=`wb_en_in`, `Result_WB`<= captured read data for loads, `alu_result_in` otherwise.
- `sram_ack` outside ACCESS ignored.

## Timing
- Non-memory instruction: 1 cycle; outputs valid the cycle after it is presented.
- Memory op presented cycle 0, ack sampled cycle n (n≥1): `sram_req` high cycles 1..n, `freeze` high cycles 0..n, DONE cycle n+1, outputs valid cycle n+2. Minimum 3-cycle latency, 2 stall cycles.
- Back-to-back memory ops: second enters IDLE the cycle after DONE; no overlap.
- Register file writes on the falling edge, so outputs are stable half a cycle before use.
- Reset mid-access: `sram_req` drops asynchronously, transaction abandoned, no write-back; a late ack is ignored.

## Configuration
- `SRAM_TIMEOUT_EN` defined: ACCESS counter; after `TIMEOUT` cycles without ack, drop `sram_req`, go DONE with read value 32'hDEADBEEF, set `mem_err` (cleared only by reset). Ack on the timeout cycle counts as success.
- Not defined: no counter; ACCESS waits indefinitely; `mem_err` tied 0.

## Test plan
- ALU op, `alu_result_in`=0x55, `dest_in`=3, `wb_en_in`=1, no mem → next cycle `Dest_wb`=3, `Result_WB`=0x55, `writeBackEn`=1, `freeze` never high.
- Load at 1028, ack 2 cycles after req, rdata 0xCAFEF00D → `sram_addr`=1, `sram_we`=0, `freeze` high 3 cycles, `Result_WB`=0xCAFEF00D at cycle 4, `writeBackEn` 0 during freeze.
- Store 0x12345678 at 1032, ack in first ACCESS cycle → `sram_we`=1, `sram_addr`=2, `sram_wdata`=0x12345678, `freeze` high 2 cycles, one `writeBackEn` pulse at most.
- Reset low during ACCESS, then ack → `sram_req` 0 immediately, state IDLE, outputs 0, ack ignored.
- Both enables with 0x400 → write only, `Result_WB`=0x400.
- `SRAM_TIMEOUT_EN`, `TIMEOUT`=4, no ack → `sram_req` drops after 4 cycles, `Result_WB`=0xDEADBEEF, `mem_err`=1 until reset.
